// File: rtl/ula_contention.sv
// ula_contention: 48K ULA raster counter, frame interrupt and CPU contention request.
// The raster (tstate/line) advances on clk35en and never stalls. A two-state
// window FSM tracks the 192-row display fetch region as (crow, ccol). The FSM
// state is visible on the internal signal cactive.
// Build option: define IO_CONTENTION_EN to also contend ULA port accesses
// (iorq_n low with a[0] low) inside the window; otherwise iorq_n is ignored.
module ula_contention #(
    parameter int TSTATES_LINE = 224,
    parameter int LINES_FRAME  = 312,
    parameter int CONT_START   = 14335,
    parameter int INT_LEN      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk35en,
    input  logic [1:0]  turbo_option,
    input  logic        disable_cont,
    input  logic [15:0] a,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        bank3_contended,
    output logic        CPUContention,
    output logic        int_n,
    output logic [7:0]  tstate,
    output logic [8:0]  line
);

    localparam logic [7:0]  TS_LAST   = 8'(TSTATES_LINE - 1);
    localparam logic [8:0]  LN_LAST   = 9'(LINES_FRAME - 1);
    localparam logic [16:0] TS_LINE_W = 17'(TSTATES_LINE);
    localparam logic [16:0] CONT_F    = 17'(CONT_START);
    localparam logic [16:0] INT_F     = 17'(INT_LEN);
    localparam logic [7:0]  CCOL_LAST = 8'd223;
    localparam logic [7:0]  CROW_LAST = 8'd191;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } cstate_t;

    cstate_t     cstate, cstate_nx;
    logic [7:0]  ccol, ccol_nx;
    logic [7:0]  crow, crow_nx;
    logic [7:0]  tstate_nx;
    logic [8:0]  line_nx;
    logic [16:0] f_nx;
    logic        cactive;
    logic        win;
    logic        mem_cont;
    logic        bus_cont;
    logic        unused_bits;

    // Next raster position, used both for the counters and the frame-position decodes.
    always_comb begin
        tstate_nx = tstate + 8'd1;
        line_nx   = line;
        if (tstate == TS_LAST) begin
            tstate_nx = 8'd0;
            line_nx   = (line == LN_LAST) ? 9'd0 : line + 9'd1;
        end
    end

    assign f_nx = ({8'd0, line_nx} * TS_LINE_W) + {9'd0, tstate_nx};

    // Raster counters and registered interrupt, updated once per T-state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tstate <= 8'd0;
            line   <= 9'd0;
            int_n  <= 1'b1;
        end else if (clk35en) begin
            tstate <= tstate_nx;
            line   <= line_nx;
            int_n  <= ~(f_nx < INT_F);
        end
    end

    // Window FSM state register together with the column/row position inside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cstate <= IDLE;
            ccol   <= 8'd0;
            crow   <= 8'd0;
        end else begin
            cstate <= cstate_nx;
            ccol   <= ccol_nx;
            crow   <= crow_nx;
        end
    end

    // Window FSM next state: entry at CONT_START takes priority over everything else.
    always_comb begin
        cstate_nx = cstate;
        ccol_nx   = ccol;
        crow_nx   = crow;
        if (clk35en) begin
            if (f_nx == CONT_F) begin
                cstate_nx = ACTIVE;
                ccol_nx   = 8'd0;
                crow_nx   = 8'd0;
            end else if (cstate == ACTIVE) begin
                if (ccol == CCOL_LAST) begin
                    ccol_nx = 8'd0;
                    if (crow == CROW_LAST) begin
                        cstate_nx = IDLE;
                        crow_nx   = 8'd0;
                    end else begin
                        crow_nx = crow + 8'd1;
                    end
                end else begin
                    ccol_nx = ccol + 8'd1;
                end
            end
        end
    end

    // Contended slots: first 128 columns of each row, 6 of every 8 T-states.
    assign cactive  = (cstate == ACTIVE);
    assign win      = cactive & (ccol < 8'd128) & (ccol[2:0] < 3'd6);
    assign mem_cont = ~mreq_n & ((a[15:14] == 2'b01) |
                                 ((a[15:14] == 2'b11) & bank3_contended));

`ifdef IO_CONTENTION_EN
    assign bus_cont = mem_cont | (~iorq_n & ~a[0]);
`else
    assign bus_cont = mem_cont;
`endif

    // Live bus inputs gate the registered window with no extra latency.
    assign CPUContention = win & bus_cont & (turbo_option == 2'b00) & ~disable_cont;

    // Address bits below A14 (and iorq_n in the default build) do not affect contention.
    assign unused_bits = &{1'b0, iorq_n, a[13:0]};

endmodule

// File: tb/tb_ula_contention.sv
// tb_ula_contention: randomized bench for ula_contention with a frame-position
// reference model (single integer F, window derived by arithmetic on F).
module tb_ula_contention;

  localparam int TS_LINE  = 224;
  localparam int FRAME    = 224 * 312;
  localparam int CONT_F   = 14335;
  localparam int WIN_LEN  = 192 * 224;
  localparam int INT_LEN  = 32;

  logic        clk;
  logic        rst_n;
  logic        clk35en;
  logic [1:0]  turbo_option;
  logic        disable_cont;
  logic [15:0] a;
  logic        mreq_n;
  logic        iorq_n;
  logic        bank3_contended;
  logic        CPUContention;
  logic        int_n;
  logic [7:0]  tstate;
  logic [8:0]  line;

  int   total;
  int   bad;
  logic chk_on;
  logic rand_bus;

  // reference model state: frame position and registered interrupt
  int   m_f;
  logic m_int;

  ula_contention dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clk35en         (clk35en),
    .turbo_option    (turbo_option),
    .disable_cont    (disable_cont),
    .a               (a),
    .mreq_n          (mreq_n),
    .iorq_n          (iorq_n),
    .bank3_contended (bank3_contended),
    .CPUContention   (CPUContention),
    .int_n           (int_n),
    .tstate          (tstate),
    .line            (line)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s at t=%0t F=%0d: got %0d expected %0d", name, $time, m_f, act, exp);
    end
  endtask

  // model: frame position advances by one per enabled T-state
  always @(posedge clk) begin
    if (!rst_n) begin
      m_f   <= 0;
      m_int <= 1'b1;
    end else if (clk35en) begin
      m_f   <= (m_f + 1) % FRAME;
      m_int <= (((m_f + 1) % FRAME) >= INT_LEN);
    end
  end

  function automatic logic m_active();
    int k;
    k = m_f - CONT_F;
    return (k >= 0) && (k < WIN_LEN);
  endfunction

  function automatic int m_ccol();
    return (m_f - CONT_F) % TS_LINE;
  endfunction

  function automatic logic exp_cont();
    int   col;
    logic w;
    logic m;
    col = m_ccol();
    w = m_active() && (col < 128) && ((col % 8) < 6);
    m = !mreq_n && ((a[15:14] == 2'b01) || ((a[15:14] == 2'b11) && bank3_contended));
`ifdef IO_CONTENTION_EN
    m = m || (!iorq_n && !a[0]);
`endif
    return w && m && (turbo_option == 2'b00) && !disable_cont;
  endfunction

  // scoreboard compare on the falling edge, away from the register updates
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tstate",  int'(tstate),        m_f % TS_LINE);
      chk("line",    int'(line),          m_f / TS_LINE);
      chk("int_n",   int'(int_n),         int'(m_int));
      chk("cactive", int'(dut.cactive),   int'(m_active()));
      chk("cont",    int'(CPUContention), int'(exp_cont()));
    end
  end

  // driver tasks
  task automatic set_bus(input logic [15:0] av, input logic mq, input logic io,
                         input logic [1:0] tb, input logic dis, input logic b3);
    a               = av;
    mreq_n          = mq;
    iorq_n          = io;
    turbo_option    = tb;
    disable_cont    = dis;
    bank3_contended = b3;
  endtask

  task automatic tick(input logic en);
    clk35en = en;
    if (rand_bus) begin
      a               = 16'($urandom_range(0, 65535));
      mreq_n          = 1'($urandom_range(0, 1));
      iorq_n          = 1'($urandom_range(0, 1));
      bank3_contended = 1'($urandom_range(0, 1));
      turbo_option    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      disable_cont    = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic rand_en();
    return ($urandom_range(0, 15) != 0);
  endfunction

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_f != target && guard < 80000) begin
      tick(rand_en());
      guard++;
    end
    chk("run_to", m_f, target);
  endtask

  initial begin
    logic [8:0] pat;
    logic       io_exp;
    int         n;
    logic       en;

    total    = 0;
    bad      = 0;
    chk_on   = 1'b0;
    rand_bus = 1'b0;
    rst_n    = 1'b0;
    clk35en  = 1'b0;
    set_bus(16'h4000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);

    // reset held for 3 cycles with clk35en high: reset must win
    repeat (3) tick(1'b1);
    chk_on = 1'b1;
    chk("rst_tstate", int'(tstate), 0);
    chk("rst_line",   int'(line), 0);
    chk("rst_int_n",  int'(int_n), 1);
    chk("rst_cont",   int'(CPUContention), 0);
    rst_n = 1'b0;

    // 64 T-states after reset with random gaps in clk35en
    rst_n = 1'b1;
    rand_bus = 1'b1;
    n = 0;
    while (n < 64) begin
      en = rand_en();
      tick(en);
      if (en) n++;
    end
    chk("t64_tstate", int'(tstate), 64);
    chk("t64_line",   int'(line), 0);
    chk("t64_int_n",  int'(int_n), 1);

    // window entry with a contended memory address
    run_to(CONT_F - 1);
    rand_bus = 1'b0;
    set_bus(16'h4000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    tick(1'b1);
    pat = 9'b1_0011_1111;
    for (int c = 0; c <= 8; c++) begin
      chk("entry_pattern", int'(CPUContention), int'(pat[c]));
      if (c < 8) tick(1'b1);
    end

    // gating variants inside the contended part of row 0
    set_bus(16'h8000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0); tick(1'b1);
    chk("gate_a8000", int'(CPUContention), 0);
    set_bus(16'h4000, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0); tick(1'b1);
    chk("gate_turbo", int'(CPUContention), 0);
    set_bus(16'h4000, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0); tick(1'b1);
    chk("gate_disable", int'(CPUContention), 0);
    set_bus(16'hC000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1); tick(1'b1);
    chk("gate_c000_b3", int'(CPUContention), 1);
    set_bus(16'hC000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0); tick(1'b1);
    chk("gate_c000_nb3", int'(CPUContention), 0);
    set_bus(16'h4000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    repeat (3) tick(1'b1);
    chk("col16_cont", int'(CPUContention), 1);
    a = 16'h8000;
    #1;
    chk("same_cycle_addr", int'(CPUContention), 0);

    // right-hand part of the row is never contended
    a = 16'h4000;
    n = 0;
    while (m_ccol() != 130 && n < 300) begin
      tick(1'b1);
      n++;
    end
    chk("col130_cont", int'(CPUContention), 0);

    // ULA port access at column 0 of the next row
`ifdef IO_CONTENTION_EN
    io_exp = 1'b1;
`else
    io_exp = 1'b0;
`endif
    set_bus(16'h00FE, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    n = 0;
    while (m_ccol() != 0 && n < 300) begin
      tick(1'b1);
      n++;
    end
    chk("io_fe", int'(CPUContention), int'(io_exp));
    a = 16'h00FF;
    #1;
    chk("io_ff", int'(CPUContention), 0);

    // window exit after row 191 column 223
    rand_bus = 1'b1;
    run_to(CONT_F + WIN_LEN - 1);
    rand_bus = 1'b0;
    set_bus(16'h4000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    #1;
    chk("exit_last_active", int'(dut.cactive), 1);
    tick(1'b1);
    chk("exit_cactive", int'(dut.cactive), 0);
    chk("exit_cont", int'(CPUContention), 0);
    repeat (50) tick(1'b1);

    // frame wrap and interrupt length
    rand_bus = 1'b1;
    run_to(FRAME - 1);
    chk("f69887_int_n", int'(int_n), 1);
    tick(1'b1);
    chk("wrap_tstate", int'(tstate), 0);
    chk("wrap_line",   int'(line), 0);
    chk("wrap_int_n",  int'(int_n), 0);
    n = 0;
    while (int_n == 1'b0 && n < 100) begin
      n++;
      tick(1'b1);
    end
    chk("int_len", n, 32);
    chk("int_end_tstate", int'(tstate), 32);

    // tail of random traffic
    repeat (300) tick(rand_en());

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
